tensor_dpu_pipe: RTL and testbench

Fixed-latency, stallable 4x2·2x4+4x4 matrix multiply-accumulate pipeline that computes one octet step of an HMMA: D = A·B + C over 32-bit integer lanes. It sits directly downstream of the tensor octet, which drives it once per completed substep pair. Its D_tile/valid_out feed the octet's result path into the per-warp commit sequencer. Stall is the only backpressure: the whole pipe freezes in place.

---
 rtl/tensor_dpu_pipe_pkg.sv | 11 +
 rtl/tensor_dpu_pipe_if.sv | 24 ++
 rtl/tensor_dpu_pipe_lane.sv | 60 ++++++
 rtl/tensor_dpu_pipe.sv | 109 ++++++++++
 tb/tb_tensor_dpu_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_dpu_pipe_pkg.sv
// Shared constants and tile types for the tensor DPU multiply-accumulate pipe.
package tensor_dpu_pipe_pkg;

    localparam int TCORE_DPU_LATENCY = 3;
    localparam int TCORE_DATAW       = 32;

    typedef logic [3:0][1:0][31:0] tcore_a_tile_t;
    typedef logic [1:0][3:0][31:0] tcore_b_tile_t;
    typedef logic [3:0][3:0][31:0] tcore_cd_tile_t;

endpackage

// File: rtl/tensor_dpu_pipe_if.sv
// Operand/result bundle between the tensor octet and the DPU pipe.
// The master side is the octet; the slave side is the pipe itself.
interface tensor_dpu_pipe_if;
    import tensor_dpu_pipe_pkg::*;

    logic           stall;
    logic           valid_in;
    tcore_a_tile_t  A_tile;
    tcore_b_tile_t  B_tile;
    tcore_cd_tile_t C_tile;
    logic           valid_out;
    tcore_cd_tile_t D_tile;

    modport master (
        output stall, valid_in, A_tile, B_tile, C_tile,
        input  valid_out, D_tile
    );

    modport slave (
        input  stall, valid_in, A_tile, B_tile, C_tile,
        output valid_out, D_tile
    );

endinterface

// File: rtl/tensor_dpu_pipe_lane.sv
// One output element of the 4x4 result: two 32-bit products plus C,
// registered as products in stage 1 and as the reduced sum in stage 2.
// Valid bits are owned by the top level and passed in as load qualifiers.
module tensor_dpu_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        s0_valid,
    input  logic        s1_valid,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [31:0] c_in,
    output logic [31:0] sum
);

    logic [31:0] p0_q, p0_d;
    logic [31:0] p1_q, p1_d;
    logic [31:0] c_q,  c_d;
    logic [31:0] sum_q, sum_d;

    // Stage 1 capture: truncated products and C load only on an advancing valid op.
    always_comb begin
        p0_d = p0_q;
        p1_d = p1_q;
        c_d  = c_q;
        if (advance && s0_valid) begin
            p0_d = a0 * b0;
            p1_d = a1 * b1;
            c_d  = c_in;
        end
    end

    // Stage 2 reduce: three-input add wrapping modulo 2^32.
    always_comb begin
        sum_d = sum_q;
        if (advance && s1_valid) begin
            sum_d = p0_q + p1_q + c_q;
        end
    end

    // Stage 1 and 2 data registers, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_q  <= '0;
            p1_q  <= '0;
            c_q   <= '0;
            sum_q <= '0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            c_q   <= c_d;
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/tensor_dpu_pipe.sv
// Fixed-latency D = A*B + C pipe for one HMMA octet step. Sixteen lanes do
// capture and reduce; the top level owns the valid shift chain and the pure
// delay stages that pad the pipe out to LATENCY. Stall freezes everything.
module tensor_dpu_pipe
    import tensor_dpu_pipe_pkg::*;
#(
    parameter int LATENCY = TCORE_DPU_LATENCY,
    parameter int DATAW   = TCORE_DATAW
) (
    input logic              clk,
    input logic              reset,
    tensor_dpu_pipe_if.slave bus
);

    if (DATAW != 32) begin : g_bad_dataw
        $error("tensor_dpu_pipe: only DATAW=32 is supported");
    end
    if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
        $error("tensor_dpu_pipe: LATENCY must be in 2..8");
    end

    logic                advance;
    logic [LATENCY-1:0]  valid_q, valid_d;
    tcore_cd_tile_t      sum_tile;

    assign advance = ~bus.stall;

    // Valid chain: bit i is stage i+1; shifts as a whole when not stalled.
    always_comb begin
        valid_d = valid_q;
        if (advance) begin
            valid_d = {valid_q[LATENCY-2:0], bus.valid_in};
        end
    end

    // Valid chain register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            tensor_dpu_lane u_lane (
                .clk      (clk),
                .reset    (reset),
                .advance  (advance),
                .s0_valid (bus.valid_in),
                .s1_valid (valid_q[0]),
                .a0       (bus.A_tile[r][0]),
                .a1       (bus.A_tile[r][1]),
                .b0       (bus.B_tile[0][c]),
                .b1       (bus.B_tile[1][c]),
                .c_in     (bus.C_tile[r][c]),
                .sum      (sum_tile[r][c])
            );
        end
    end

    if (LATENCY == 2) begin : g_no_delay
        assign bus.D_tile = sum_tile;
    end else begin : g_delay
        localparam int NDLY = LATENCY - 2;

        tcore_cd_tile_t dly_q [NDLY];
        tcore_cd_tile_t dly_d [NDLY];

        // Delay stage i loads from its predecessor only when that stage holds a valid result.
        always_comb begin
            for (int i = 0; i < NDLY; i++) begin
                dly_d[i] = dly_q[i];
            end
            if (advance && valid_q[1]) begin
                dly_d[0] = sum_tile;
            end
            for (int i = 1; i < NDLY; i++) begin
                if (advance && valid_q[i+1]) begin
                    dly_d[i] = dly_q[i-1];
                end
            end
        end

        // Delay stage data registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < NDLY; i++) begin
                    dly_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NDLY; i++) begin
                    dly_q[i] <= dly_d[i];
                end
            end
        end

        assign bus.D_tile = dly_q[NDLY-1];
    end

    assign bus.valid_out = valid_q[LATENCY-1];

    // Upstream never issues into a frozen pipe; such an op would be lost.
    a_no_issue_while_stalled: assert property (
        @(posedge clk) disable iff (reset) !(bus.valid_in && bus.stall)
    );

endmodule

// File: tb/tb_tensor_dpu_pipe.sv
// Bench for tensor_dpu_pipe: LATENCY=3 main instance plus LATENCY=2 and 8
// instances for the latency sweep. Expected tiles come from a direct
// per-element formula and are queued at issue time.
module tb_tensor_dpu_pipe;
    import tensor_dpu_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    tcore_cd_tile_t exp_q[$];

    tensor_dpu_pipe_if bus3 ();
    tensor_dpu_pipe_if bus2 ();
    tensor_dpu_pipe_if bus8 ();

    tensor_dpu_pipe #(.LATENCY(3), .DATAW(32)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    tensor_dpu_pipe #(.LATENCY(2), .DATAW(32)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    tensor_dpu_pipe #(.LATENCY(8), .DATAW(32)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // Free-running clock, rising edge active.
    initial forever #5 clk = ~clk;

    function automatic tcore_cd_tile_t model(input tcore_a_tile_t a, input tcore_b_tile_t b,
                                             input tcore_cd_tile_t c);
        tcore_cd_tile_t d;
        logic [31:0] t0, t1;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                t0 = a[r][0] * b[0][col];
                t1 = a[r][1] * b[1][col];
                d[r][col] = t0 + t1 + c[r][col];
            end
        end
        return d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus3.stall = 1'b0; bus3.valid_in = 1'b0; bus3.A_tile = '0; bus3.B_tile = '0; bus3.C_tile = '0;
        bus2.stall = 1'b0; bus2.valid_in = 1'b0; bus2.A_tile = '0; bus2.B_tile = '0; bus2.C_tile = '0;
        bus8.stall = 1'b0; bus8.valid_in = 1'b0; bus8.A_tile = '0; bus8.B_tile = '0; bus8.C_tile = '0;
    endtask

    task automatic issue_main(input tcore_a_tile_t a, input tcore_b_tile_t b, input tcore_cd_tile_t c);
        bus3.A_tile   = a;
        bus3.B_tile   = b;
        bus3.C_tile   = c;
        bus3.valid_in = 1'b1;
        exp_q.push_back(model(a, b, c));
    endtask

    task automatic make_const(output tcore_a_tile_t a, output tcore_b_tile_t b, output tcore_cd_tile_t c);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) a[i][j] = 32'd1;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) b[i][j] = 32'd2;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 32'd3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        cyc();
        cyc();
        checks++;
        if (bus3.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid3: got %0b expected 0", bus3.valid_out); end
        checks++;
        if (bus3.D_tile !== '0) begin errors++; $display("[TB] FAIL reset_d3: got %h expected 0", bus3.D_tile); end
        checks++;
        if (bus2.valid_out !== 1'b0 || bus8.valid_out !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid_sweep: got %0b/%0b expected 0/0", bus2.valid_out, bus8.valid_out);
        end
        checks++;
        if (bus2.D_tile !== '0 || bus8.D_tile !== '0) begin
            errors++; $display("[TB] FAIL reset_d_sweep: got nonzero expected 0");
        end
        reset = 1'b0;
        cyc();
    endtask

    // Issues one op and checks latency, value, and the held value after drain.
    task automatic run_one(input string name, input tcore_a_tile_t a, input tcore_b_tile_t b,
                           input tcore_cd_tile_t c, output tcore_cd_tile_t got);
        tcore_cd_tile_t exp;
        int lat;
        issue_main(a, b, c);
        exp = exp_q[$];
        cyc();
        bus3.valid_in = 1'b0;
        lat = 1;
        while (!bus3.valid_out && lat < 20) begin
            cyc();
            lat++;
        end
        got = bus3.D_tile;
        checks++;
        if (lat != 3) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected 3", name, lat); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL %s_value: got %h expected %h", name, got, exp); end
        cyc();
        checks++;
        if (bus3.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL %s_drain_valid: got %0b expected 0", name, bus3.valid_out); end
        checks++;
        if (bus3.D_tile !== exp) begin errors++; $display("[TB] FAIL %s_drain_hold: got %h expected %h", name, bus3.D_tile, exp); end
    endtask

    task automatic test_single_op();
        tcore_a_tile_t a; tcore_b_tile_t b; tcore_cd_tile_t c; tcore_cd_tile_t got;
        make_const(a, b, c);
        run_one("single", a, b, c, got);
        checks++;
        if (got[2][3] !== 32'd7) begin errors++; $display("[TB] FAIL single_d23: got %h expected 7", got[2][3]); end
    endtask

    task automatic test_distinct();
        tcore_a_tile_t a; tcore_b_tile_t b; tcore_cd_tile_t c; tcore_cd_tile_t got;
        for (int r = 0; r < 4; r++) for (int k = 0; k < 2; k++) a[r][k] = 32'(r + k);
        for (int k = 0; k < 2; k++) for (int col = 0; col < 4; col++) b[k][col] = 32'(col - k);
        for (int r = 0; r < 4; r++) for (int col = 0; col < 4; col++) c[r][col] = 32'(16 * r + col);
        run_one("distinct", a, b, c, got);
        // D[3][0] = 3*0 + 4*(-1) + 48 = 44
        checks++;
        if (got[3][0] !== 32'd44) begin errors++; $display("[TB] FAIL distinct_d30: got %h expected 2c", got[3][0]); end
    endtask

    task automatic test_wrap();
        tcore_a_tile_t a; tcore_b_tile_t b; tcore_cd_tile_t c; tcore_cd_tile_t got;
        a = '0; b = '0; c = '0;
        a[0][0] = 32'h8000_0000;
        b[0][0] = 32'd2;
        a[0][1] = 32'hFFFF_FFFF;
        b[1][0] = 32'd1;
        c[0][0] = 32'd1;
        run_one("wrap", a, b, c, got);
        checks++;
        if (got[0][0] !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_d00: got %h expected 0", got[0][0]); end
    endtask

    task automatic test_back_to_back();
        tcore_a_tile_t oa[4]; tcore_b_tile_t ob[4]; tcore_cd_tile_t oc[4];
        tcore_cd_tile_t held, exp;
        int issued = 0, received = 0, stall_left = 0, cnt = 0, done_at = -1;
        bit stall_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 4; r++) for (int k = 0; k < 2; k++) oa[i][r][k] = $urandom();
            for (int k = 0; k < 2; k++) for (int col = 0; col < 4; col++) ob[i][k][col] = $urandom();
            for (int r = 0; r < 4; r++) for (int col = 0; col < 4; col++) oc[i][r][col] = $urandom();
        end
        held = '0;
        bus3.stall = 1'b0;
        while (received < 4 && cnt < 100) begin
            if (bus3.valid_out) begin
                if (!stall_done) begin
                    stall_done = 1'b1;
                    stall_left = 5;
                    held = bus3.D_tile;
                end
                if (stall_left > 0) begin
                    if (bus3.stall) begin
                        checks++;
                        if (bus3.D_tile !== held) begin
                            errors++; $display("[TB] FAIL stall_hold: got %h expected %h", bus3.D_tile, held);
                        end
                    end
                    bus3.stall = 1'b1;
                    stall_left--;
                end else begin
                    bus3.stall = 1'b0;
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (bus3.D_tile !== exp) begin
                        errors++; $display("[TB] FAIL b2b_result%0d: got %h expected %h", received, bus3.D_tile, exp);
                    end
                    received++;
                    if (received == 4) done_at = cnt;
                end
            end else begin
                bus3.stall = 1'b0;
            end
            if (!bus3.stall && issued < 4) begin
                issue_main(oa[issued], ob[issued], oc[issued]);
                issued++;
            end else begin
                bus3.valid_in = 1'b0;
            end
            cyc();
            cnt++;
        end
        bus3.stall = 1'b0;
        bus3.valid_in = 1'b0;
        checks++;
        if (received != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", received); end
        checks++;
        if (done_at != 11) begin errors++; $display("[TB] FAIL b2b_completion: got %0d expected 11", done_at); end
        exp_q.delete();
        cyc();
    endtask

    task automatic test_reset_midflight();
        tcore_a_tile_t a; tcore_b_tile_t b; tcore_cd_tile_t c;
        int seen = 0;
        make_const(a, b, c);
        issue_main(a, b, c);
        cyc();
        c[1][1] = 32'd100;
        issue_main(a, b, c);
        cyc();
        bus3.valid_in = 1'b0;
        cyc();
        checks++;
        if (bus3.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL midflight_pre_valid: got %0b expected 1", bus3.valid_out); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus3.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL midflight_valid_drop: got %0b expected 0", bus3.valid_out); end
        checks++;
        if (bus3.D_tile !== '0) begin errors++; $display("[TB] FAIL midflight_d_drop: got %h expected 0", bus3.D_tile); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus3.valid_out) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL midflight_ghost: got %0d results expected 0", seen); end
    endtask

    task automatic test_param_sweep();
        tcore_a_tile_t a; tcore_b_tile_t b; tcore_cd_tile_t c; tcore_cd_tile_t exp, d2, d8;
        int lat, first2, first8;
        make_const(a, b, c);
        exp = model(a, b, c);
        bus2.A_tile = a; bus2.B_tile = b; bus2.C_tile = c; bus2.valid_in = 1'b1;
        bus8.A_tile = a; bus8.B_tile = b; bus8.C_tile = c; bus8.valid_in = 1'b1;
        cyc();
        bus2.valid_in = 1'b0;
        bus8.valid_in = 1'b0;
        lat = 1; first2 = 0; first8 = 0; d2 = '0; d8 = '0;
        while (lat < 20) begin
            if (bus2.valid_out && first2 == 0) begin first2 = lat; d2 = bus2.D_tile; end
            if (bus8.valid_out && first8 == 0) begin first8 = lat; d8 = bus8.D_tile; end
            if (first8 != 0) break;
            cyc();
            lat++;
        end
        checks++;
        if (first2 != 2) begin errors++; $display("[TB] FAIL lat2_latency: got %0d expected 2", first2); end
        checks++;
        if (first8 != 8) begin errors++; $display("[TB] FAIL lat8_latency: got %0d expected 8", first8); end
        checks++;
        if (d2 !== exp) begin errors++; $display("[TB] FAIL lat2_value: got %h expected %h", d2, exp); end
        checks++;
        if (d8 !== exp) begin errors++; $display("[TB] FAIL lat8_value: got %h expected %h", d8, exp); end
        checks++;
        if (bus2.valid_out !== 1'b0 || bus2.D_tile !== exp) begin
            errors++; $display("[TB] FAIL lat2_hold: got valid %0b d %h expected valid 0 d %h", bus2.valid_out, bus2.D_tile, exp);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_op();
        test_distinct();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
